// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared constants, state encoding and operand-forwarding helper for the M-extension unit
package rv32m_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } md_state_e;

   // The reserved code 01 falls back to the register-file value.
   function automatic logic [XLEN-1:0] fwd_select(input logic [1:0] sel,
                                                  input logic [XLEN-1:0] rs,
                                                  input logic [XLEN-1:0] mem,
                                                  input logic [XLEN-1:0] wb);
      case (sel)
         FWD_MEM: return mem;
         FWD_WB:  return wb;
         default: return rs;
      endcase
   endfunction

endpackage

// File: rtl/ex_div_iter.sv
// rtl/ex_div_iter.sv - radix-2 restoring divider on unsigned magnitudes, one quotient bit per step
module ex_div_iter (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_step,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic [4:0]  o_count,
   output logic [31:0] o_quotient,
   output logic [31:0] o_remainder
);

   logic [31:0] r_quo;
   logic [31:0] r_rem;
   logic [31:0] r_divisor;
   logic [4:0]  r_count;
   logic [32:0] w_shift;
   logic [32:0] w_trial;
   logic        w_fits;

   // Borrow out of the 33-bit trial subtraction means the divisor did not fit.
   assign w_shift = {r_rem, r_quo[31]};
   assign w_trial = w_shift - {1'b0, r_divisor};
   assign w_fits  = !w_trial[32];

   // Outputs are the values after the current step, so the parent can
   // capture the final result on the same cycle as the last step.
   assign o_quotient  = {r_quo[30:0], w_fits};
   assign o_remainder = w_fits ? w_trial[31:0] : w_shift[31:0];
   assign o_count     = r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_quo     <= '0;
         r_rem     <= '0;
         r_divisor <= '0;
         r_count   <= '0;
      end else if (i_start) begin
         r_quo     <= i_dividend;
         r_rem     <= '0;
         r_divisor <= i_divisor;
         r_count   <= '0;
      end else if (i_step) begin
         r_quo     <= o_quotient;
         r_rem     <= o_remainder;
         r_count   <= r_count + 5'd1;
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - RV32M execute-stage multiply/divide unit with operand forwarding and pipeline stall
module ex_muldiv_unit
   import rv32m_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_rs1_data,
   input  logic [31:0] i_rs2_data,
   input  logic [31:0] i_MEM_alu_result,
   input  logic [31:0] i_WB_data,
   input  logic [1:0]  i_ctrl_ForwardA,
   input  logic [1:0]  i_ctrl_ForwardB,
   input  logic        i_flush,
   output logic        o_stall,
   output logic        o_done,
   output logic [31:0] o_result
);

   md_state_e   r_state;
   md_state_e   w_state_next;
   logic [2:0]  r_funct3;
   logic [31:0] r_op_a;
   logic [31:0] r_op_b;
   logic [31:0] r_result;
   logic        r_done;

   logic [31:0] w_op_a;
   logic [31:0] w_op_b;
   logic        w_accept;
   logic        w_in_signed;
   logic        w_div0;
   logic        w_ovf;
   logic [31:0] w_special;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;

   logic        w_load;
   logic [31:0] w_result_next;

   assign w_op_a   = fwd_select(i_ctrl_ForwardA, i_rs1_data, i_MEM_alu_result, i_WB_data);
   assign w_op_b   = fwd_select(i_ctrl_ForwardB, i_rs2_data, i_MEM_alu_result, i_WB_data);
   assign w_accept = (r_state == S_IDLE) && i_valid && !i_flush;

   // Divide-class decode on the live operands; DIV and REM are the signed ones (funct3[0]=0).
   assign w_in_signed = !i_funct3[0];
   assign w_div0      = (w_op_b == 32'd0);
   assign w_ovf       = w_in_signed && (w_op_a == 32'h8000_0000) && (w_op_b == 32'hFFFF_FFFF);
   assign w_special   = i_funct3[1] ? (w_div0 ? w_op_a : 32'd0)
                                    : (w_div0 ? 32'hFFFF_FFFF : 32'h8000_0000);
   assign w_mag_a     = (w_in_signed && w_op_a[31]) ? (32'd0 - w_op_a) : w_op_a;
   assign w_mag_b     = (w_in_signed && w_op_b[31]) ? (32'd0 - w_op_b) : w_op_b;

   // Multiply: both operands extended to 64 bits, so one modular product covers all four ops.
   logic        w_a_sext;
   logic        w_b_sext;
   logic [63:0] w_a64;
   logic [63:0] w_b64;
   logic [63:0] w_prod;
   logic [31:0] w_mul_result;

   assign w_a_sext     = ((r_funct3 == F3_MULH) || (r_funct3 == F3_MULHSU)) && r_op_a[31];
   assign w_b_sext     = (r_funct3 == F3_MULH) && r_op_b[31];
   assign w_a64        = {{32{w_a_sext}}, r_op_a};
   assign w_b64        = {{32{w_b_sext}}, r_op_b};
   assign w_prod       = w_a64 * w_b64;
   assign w_mul_result = (r_funct3 == F3_MUL) ? w_prod[31:0] : w_prod[63:32];

   logic [4:0]  w_div_count;
   logic [31:0] w_quo_mag;
   logic [31:0] w_rem_mag;
   logic        w_div_signed;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;
   logic [31:0] w_div_result;

   ex_div_iter u_div (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_start     (w_accept),
      .i_step      (r_state == S_DIV),
      .i_dividend  (w_mag_a),
      .i_divisor   (w_mag_b),
      .o_count     (w_div_count),
      .o_quotient  (w_quo_mag),
      .o_remainder (w_rem_mag)
   );

   assign w_div_signed = !r_funct3[0];
   assign w_quo_fix    = (w_div_signed && (r_op_a[31] ^ r_op_b[31])) ? (32'd0 - w_quo_mag) : w_quo_mag;
   assign w_rem_fix    = (w_div_signed && r_op_a[31]) ? (32'd0 - w_rem_mag) : w_rem_mag;
   assign w_div_result = r_funct3[1] ? w_rem_fix : w_quo_fix;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_funct3 <= '0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= (w_state_next == S_DONE);
         if (w_accept) begin
            r_funct3 <= i_funct3;
            r_op_a   <= w_op_a;
            r_op_b   <= w_op_b;
         end
         if (w_load) begin
            r_result <= w_result_next;
         end
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_load        = 1'b0;
      w_result_next = r_result;
      o_stall       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               o_stall = 1'b1;
               if (!i_funct3[2]) begin
                  w_state_next = S_MUL;
               end else if (w_div0 || w_ovf) begin
                  w_state_next  = S_DONE;
                  w_load        = 1'b1;
                  w_result_next = w_special;
               end else begin
                  w_state_next = S_DIV;
               end
            end
         end
         S_MUL: begin
            o_stall       = 1'b1;
            w_state_next  = S_DONE;
            w_load        = 1'b1;
            w_result_next = w_mul_result;
         end
         S_DIV: begin
            o_stall = 1'b1;
            if (w_div_count == 5'd31) begin
               w_state_next  = S_DONE;
               w_load        = 1'b1;
               w_result_next = w_div_result;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
      endcase
      // A flush kills whatever is in EX, including a result about to be loaded.
      if (i_flush) begin
         w_state_next = S_IDLE;
         w_load       = 1'b0;
         o_stall      = 1'b0;
      end
   end

   assign o_done   = r_done;
   assign o_result = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit with directed and randomized M-ops
module tb_ex_muldiv_unit;

   logic        i_clk;
   logic        i_rst;
   logic        i_valid;
   logic [2:0]  i_funct3;
   logic [31:0] i_rs1_data;
   logic [31:0] i_rs2_data;
   logic [31:0] i_MEM_alu_result;
   logic [31:0] i_WB_data;
   logic [1:0]  i_ctrl_ForwardA;
   logic [1:0]  i_ctrl_ForwardB;
   logic        i_flush;
   logic        o_stall;
   logic        o_done;
   logic [31:0] o_result;

   int checks = 0;
   int errors = 0;

   ex_muldiv_unit dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_valid          (i_valid),
      .i_funct3         (i_funct3),
      .i_rs1_data       (i_rs1_data),
      .i_rs2_data       (i_rs2_data),
      .i_MEM_alu_result (i_MEM_alu_result),
      .i_WB_data        (i_WB_data),
      .i_ctrl_ForwardA  (i_ctrl_ForwardA),
      .i_ctrl_ForwardB  (i_ctrl_ForwardB),
      .i_flush          (i_flush),
      .o_stall          (o_stall),
      .o_done           (o_done),
      .o_result         (o_result)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rs, mem, wb);
      if (sel == 2'b10) return mem;
      if (sel == 2'b11) return wb;
      return rs;
   endfunction

   // Reference: RISC-V M semantics written directly as wide integer arithmetic.
   function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, b);
      longint      sa, sb, ua, ub, p;
      logic [63:0] pu;
      int          ia, ib;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = $signed(a);
      ib = $signed(b);
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin pu = ua * ub; return pu[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return ia % ib;
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, b);
      if (!f3[2]) return 2;
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one M-op in the next cycle and follow it to o_done.
   task automatic do_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] rs1, rs2, mem, wb,
                        input logic [1:0] fa, fb, input logic [31:0] exp_res);
      logic [31:0] a, b;
      logic [63:0] obs_stall, exp_stall;
      int          lat, done_t;
      a = fwd(fa, rs1, mem, wb);
      b = fwd(fb, rs2, mem, wb);
      lat = exp_lat(f3, a, b);
      exp_stall = (64'd1 << lat) - 64'd1;
      obs_stall = '0;
      done_t = -1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      i_flush = 1'b0;
      i_valid = 1'b1;
      i_funct3 = f3;
      i_rs1_data = rs1;
      i_rs2_data = rs2;
      i_MEM_alu_result = mem;
      i_WB_data = wb;
      i_ctrl_ForwardA = fa;
      i_ctrl_ForwardB = fb;
      for (int t = 0; t < 40; t++) begin
         if (t > 0) begin
            @(posedge i_clk); #1;
            i_MEM_alu_result = $urandom;
            i_WB_data = $urandom;
         end
         @(negedge i_clk);
         obs_stall[t] = o_stall;
         if (o_done) begin
            done_t = t;
            break;
         end
      end
      chk({tag, ".latency"}, 64'(done_t), 64'(lat));
      chk({tag, ".stall"}, obs_stall, exp_stall);
      chk({tag, ".result"}, {32'd0, o_result}, {32'd0, exp_res});
   endtask

   task automatic idle_cycle(input string tag);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_flush = 1'b0;
      i_rst = 1'b0;
      @(negedge i_clk);
      chk({tag, ".idle_stall"}, {63'd0, o_stall}, 64'd0);
      chk({tag, ".idle_done"}, {63'd0, o_done}, 64'd0);
   endtask

   // Start a DIV 100/7 and kill it at cycle kill_t with flush or reset.
   task automatic kill_div(input string tag, input int kill_t, input logic use_rst);
      logic saw_done;
      saw_done = 1'b0;
      @(posedge i_clk); #1;
      i_valid = 1'b1;
      i_funct3 = 3'b100;
      i_rs1_data = 32'd100;
      i_rs2_data = 32'd7;
      i_ctrl_ForwardA = 2'b00;
      i_ctrl_ForwardB = 2'b00;
      for (int t = 0; t <= kill_t; t++) begin
         if (t > 0) begin
            @(posedge i_clk); #1;
         end
         if (t == kill_t) begin
            if (use_rst) i_rst = 1'b1;
            else i_flush = 1'b1;
         end
         @(negedge i_clk);
         if (o_done) saw_done = 1'b1;
         if (t == kill_t && !use_rst)
            chk({tag, ".flush_stall"}, {63'd0, o_stall}, 64'd0);
      end
      chk({tag, ".no_done"}, {63'd0, saw_done}, 64'd0);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] rs1, rs2, mem, wb;
      logic [1:0]  fa, fb;

      i_rst = 1'b1;
      i_valid = 1'b0;
      i_funct3 = '0;
      i_rs1_data = '0;
      i_rs2_data = '0;
      i_MEM_alu_result = '0;
      i_WB_data = '0;
      i_ctrl_ForwardA = '0;
      i_ctrl_ForwardB = '0;
      i_flush = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("reset.stall", {63'd0, o_stall}, 64'd0);
      chk("reset.done", {63'd0, o_done}, 64'd0);
      chk("reset.result", {32'd0, o_result}, 64'd0);

      do_op("mul_fwdmem", 3'b000, 32'h1234_5678, 32'hFFFF_FFFD, 32'd7, 32'd0, 2'b10, 2'b00, 32'hFFFF_FFEB);
      do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 2'b00, 2'b00, 32'hFFFF_FFFE);
      do_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 2'b00, 2'b00, 32'h0000_0000);
      do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 2'b00, 2'b00, 32'hFFFF_FFFF);
      idle_cycle("gap0");
      do_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 2'b00, 2'b00, 32'hFFFF_FFFD);
      do_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 2'b00, 2'b00, 32'hFFFF_FFFF);
      do_op("divu", 3'b101, 32'd100, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00, 32'd14);
      do_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 32'hFFFF_FFFF);
      do_op("rem_by0", 3'b110, 32'd5, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 32'd5);
      do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 2'b00, 2'b00, 32'h8000_0000);
      do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 2'b00, 2'b00, 32'd0);
      do_op("mul_fwdwb", 3'b000, 32'd4, 32'd0, 32'd0, 32'd3, 2'b00, 2'b11, 32'd12);
      idle_cycle("gap1");

      kill_div("flush", 10, 1'b0);
      do_op("mul_after_flush", 3'b000, 32'd6, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00, 32'd42);
      idle_cycle("gap2");
      kill_div("reset", 5, 1'b1);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      i_valid = 1'b0;
      @(negedge i_clk);
      chk("reset_mid.result", {32'd0, o_result}, 64'd0);
      chk("reset_mid.done", {63'd0, o_done}, 64'd0);
      do_op("mul_after_reset", 3'b011, 32'h0001_0000, 32'h0003_0000, 32'd0, 32'd0, 2'b00, 2'b00, 32'd3);

      for (int n = 0; n < 24; n++) begin
         f3 = 3'($urandom_range(0, 7));
         rs1 = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 6))
            0: rs2 = 32'd0;
            1: rs2 = 32'hFFFF_FFFF;
            2: rs2 = $urandom_range(1, 15);
            default: rs2 = $urandom;
         endcase
         mem = $urandom;
         wb = $urandom;
         fa = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         fb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         do_op($sformatf("rand%0d_f%0d", n, f3), f3, rs1, rs2, mem, wb, fa, fb,
               ref_md(f3, fwd(fa, rs1, mem, wb), fwd(fb, rs2, mem, wb)));
         if (n % 4 == 3) idle_cycle($sformatf("rgap%0d", n));
      end

      idle_cycle("final");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
